mdio_arbiter: RTL and testbench

MDIO_ARBITER -- requirements
Module: mdio_arbiter

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_rr_pick.sv | 15 +
 rtl/mdio_arbiter.sv | 147 ++++++++++++++
 tb/tb_mdio_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types for the MDIO arbiter: FSM states, frame layout and frame legality helpers.
package mdio_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_t;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [1:0] OP_WR    = 2'b01;

    // Packed MSB-first: st=[31:30] op=[29:28] phy=[27:23] reg=[22:18] ta=[17:16] data=[15:0]
    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy_addr;
        logic [4:0]  reg_addr;
        logic [1:0]  ta;
        logic [15:0] data;
    } mdio_frame_t;

    function automatic logic frame_legal(input mdio_frame_t f);
        return (f.st == ST_START) && ((f.op == OP_RD) || (f.op == OP_WR));
    endfunction

    function automatic logic frame_is_read(input mdio_frame_t f);
        return f.op == OP_RD;
    endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, on a tie the one not granted last wins.
module mdio_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = valid0 && (!valid1 || last);
        grant1 = valid1 && (!valid0 || !last);
    end

endmodule

// File: rtl/mdio_arbiter.sv
// Arbitrates two MDIO frame requesters onto one MDIO generator, one transaction at a time.
// Optional WAIT-state abort enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        gen_start,
    output logic [31:0] gen_t_data,
    input  logic        gen_done,
    input  logic [15:0] gen_rd_data,
    output logic        busy
);

    arb_state_t  state_q, state_d;
    mdio_frame_t frame_q;
    logic        id_q;
    logic        last_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        grant0, grant1;
    logic        legal;
    logic        timeout_hit;

    mdio_rr_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last_q),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign legal = frame_legal(frame_q);

`ifdef MDIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state_q != S_WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a gen_done in that same cycle still wins.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant0 || grant1) state_d = S_ISSUE;
            S_ISSUE: state_d = legal ? S_WAIT : S_RESP;
            S_WAIT:  if (gen_done || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        frame_q <= grant1 ? req1_data : req0_data;
                        id_q    <= grant1;
                    end
                end
                S_ISSUE: begin
                    if (!legal) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (gen_done) begin
                        rdata_q <= frame_is_read(frame_q) ? gen_rd_data : '0;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_RESP:  last_q <= id_q;
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst so a reset mid-transaction never leaks a pulse.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        gen_start   = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                end
                S_ISSUE: gen_start = legal;
                S_RESP: begin
                    resp0_valid = !id_q;
                    resp1_valid = id_q;
                end
                default: ;
            endcase
        end
    end

    assign gen_t_data = frame_q;
    assign resp_data  = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: randomized rounds against a transaction-level model.
module tb_mdio_arbiter;

    localparam int TO = 16;
`ifdef MDIO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        gen_start;
    logic [31:0] gen_t_data;
    logic        gen_done = 1'b0;
    logic [15:0] gen_rd_data = '0;
    logic        busy;

    mdio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .resp_err(resp_err),
        .gen_start(gen_start), .gen_t_data(gen_t_data),
        .gen_done(gen_done), .gen_rd_data(gen_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit id; logic [31:0] frame; } gnt_t;
    typedef struct { bit id; logic [15:0] data; bit err; int kind; } exp_t;  // kind: 0 done, 1 illegal, 2 timeout
    typedef struct { logic [15:0] d; int dly; } gen_t;

    gnt_t gnt_q[$];
    exp_t exp_q[$];
    gen_t gen_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit m_last   = 1'b1;
    bit gen_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit f_legal(input logic [31:0] f);
        return (f[31:30] == 2'b01) && (f[29:28] == 2'b10 || f[29:28] == 2'b01);
    endfunction

    // Generator model: answers each gen_start after dly cycles; dly 0 never answers.
    initial begin
        gen_t g;
        int n;
        forever begin
            @(negedge clk);
            if (gen_start && !rst && gen_q.size() > 0) begin
                g = gen_q.pop_front();
                if (g.dly != 0) begin
                    gen_busy = 1'b1;
                    n = (g.dly < 0) ? -g.dly : g.dly;
                    repeat (n) @(posedge clk);
                    #1 gen_done = 1'b1;
                    gen_rd_data = g.d;
                    @(posedge clk);
                    #1 gen_done = 1'b0;
                    gen_rd_data = 16'($urandom);
                    gen_busy = 1'b0;
                end
            end
        end
    end

    // Monitor
    bit          cur_act = 0, cur_legal = 0, in_wait = 0, exp_start;
    logic [31:0] cur_frame = '0;
    int          ready_cyc = 0, start_cyc = 0, done_cyc = 0, exp_cyc;

    always @(negedge clk) begin
        gnt_t g;
        exp_t e;
        if (rst) begin
            cur_act = 0;
            in_wait = 0;
        end else begin
            if (req0_ready || req1_ready) begin
                if (gnt_q.size() == 0) begin
                    check("ready_unexpected", {req1_ready, req0_ready}, 0);
                end else begin
                    g = gnt_q.pop_front();
                    check("grant_id", {req1_ready, req0_ready}, g.id ? 2'b10 : 2'b01);
                    cur_frame = g.frame;
                    cur_legal = f_legal(g.frame);
                    ready_cyc = cyc;
                    cur_act   = 1;
                end
            end
            exp_start = cur_act && (cyc == ready_cyc + 1) && cur_legal;
            if (gen_start || exp_start) begin
                check("gen_start", gen_start, exp_start);
                if (gen_start) begin
                    check("gen_t_data", gen_t_data, cur_frame);
                    in_wait   = 1;
                    start_cyc = cyc;
                end
            end else if (in_wait) begin
                check("gen_t_data_stable", gen_t_data, cur_frame);
                if (gen_done) begin
                    in_wait  = 0;
                    done_cyc = cyc;
                end
            end
            if (resp0_valid || resp1_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {resp1_valid, resp0_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", {resp1_valid, resp0_valid}, e.id ? 2'b10 : 2'b01);
                    check("resp_data", resp_data, e.data);
                    check("resp_err", resp_err, e.err);
                    exp_cyc = (e.kind == 0) ? done_cyc + 1 :
                              (e.kind == 1) ? ready_cyc + 2 : start_cyc + TO + 1;
                    check("resp_latency", cyc, exp_cyc);
                end
                cur_act = 0;
                in_wait = 0;
            end
        end
    end

    task automatic wait_empty();
        int i;
        for (i = 0; i < 3000 && (exp_q.size() != 0 || gen_busy); i++) @(posedge clk);
        if (i >= 3000) check("resp_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_round(input bit v0, input bit v1,
                             input logic [31:0] f0, input logic [31:0] f1,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input int dl0, input int dl1, input bit expect_resp);
        bit          order [2];
        int          n;
        bit          id, pend0, pend1, drop0, drop1;
        logic [31:0] f;
        logic [15:0] d;
        int          dl, i;
        if (v0 && v1) begin
            order[0] = (m_last == 1'b1) ? 1'b0 : 1'b1;
            order[1] = !order[0];
            n = 2;
        end else begin
            order[0] = v1;
            order[1] = v1;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            id = order[k];
            f  = id ? f1 : f0;
            d  = id ? d1 : d0;
            dl = id ? dl1 : dl0;
            gnt_q.push_back('{id, f});
            if (f_legal(f)) begin
                gen_q.push_back('{d, dl});
                if (expect_resp) begin
                    if (TO_EN && (dl <= 0 || dl > TO))
                        exp_q.push_back('{id, 16'h0, 1'b1, 2});
                    else
                        exp_q.push_back('{id, (f[29:28] == 2'b10) ? d : 16'h0, 1'b0, 0});
                end
            end else if (expect_resp) begin
                exp_q.push_back('{id, 16'h0, 1'b1, 1});
            end
        end
        m_last = order[n-1];

        @(posedge clk);
        #1;
        if (v0) begin req0_data = f0; req0_valid = 1'b1; end
        if (v1) begin req1_data = f1; req1_valid = 1'b1; end
        pend0 = v0;
        pend1 = v1;
        for (i = 0; i < 3000 && (pend0 || pend1); i++) begin
            @(negedge clk);
            drop0 = pend0 && req0_ready;
            drop1 = pend1 && req1_ready;
            @(posedge clk);
            #1;
            if (drop0) begin req0_valid = 1'b0; pend0 = 0; end
            if (drop1) begin req1_valid = 1'b0; pend1 = 0; end
        end
        if (pend0 || pend1) begin
            check("grant_timeout", {pend1, pend0}, 0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        if (expect_resp) wait_empty();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, gen_start, busy}, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_gen_t_data", gen_t_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1'b1;
        gnt_q.delete();
        gen_q.delete();
        @(negedge clk);
        check("busy_after_rst", busy, 0);
    endtask

    function automatic logic [31:0] rand_frame();
        logic [31:0] f;
        f = $urandom;
        if ($urandom_range(3) != 0) begin
            f[31:30] = 2'b01;
            f[29:28] = ($urandom_range(1) != 0) ? 2'b10 : 2'b01;
        end
        return f;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fa, fb;
        int          mask;
        apply_reset();

        // Long read from req0 while req1 blips valid during busy and must never be served.
        fork
            run_round(1, 0, 32'h6082_0000, 32'h0, 16'hBEEF, 16'h0, 40, 0, 1);
            begin
                repeat (8) @(posedge clk);
                #1 req1_valid = 1'b1;
                req1_data = 32'h5082_0000;
                repeat (3) @(posedge clk);
                #1 req1_valid = 1'b0;
            end
        join

        repeat (2)
            run_round(1, 1, 32'h6102_0000, 32'h5104_5555, 16'h1357, 16'h2468,
                      $urandom_range(1, 10), $urandom_range(1, 10), 1);

        run_round(0, 1, 32'h0, 32'h5082_1234, 16'h0, 16'hFFFF, 0, 12, 1);
        run_round(1, 0, 32'h2082_0000, 32'h0, 16'h0, 16'h0, 5, 0, 1);

        // Reset while the generator never answers.
        run_round(1, 0, 32'h6082_0000, 32'h0, 16'hDEAD, 16'h0, 0, 0, 0);
        repeat (6) @(posedge clk);
        apply_reset();
        run_round(1, 1, 32'h6082_0001, 32'h6082_0002, 16'hA1A1, 16'hB2B2, 3, 4, 1);

`ifdef MDIO_ARB_TIMEOUT_EN
        run_round(1, 0, 32'h6082_0000, 32'h0, 16'hCAFE, 16'h0, -30, 0, 1);
`endif

        for (int r = 0; r < 30; r++) begin
            mask = $urandom_range(1, 3);
            fa = rand_frame();
            fb = rand_frame();
            run_round(mask[0], mask[1], fa, fb, 16'($urandom), 16'($urandom),
                      $urandom_range(1, 12), $urandom_range(1, 12), 1);
        end

        repeat (5) @(posedge clk);
        check("gnt_q_drained", gnt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
